// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states, lane-select widths.
// The ERR state exists only when LSU_MISALIGN_TRAP_EN is defined.
package lsu_pkg;

  localparam int LANE_SEL_W = 2;
  localparam int HALF_SEL_W = 1;
  localparam int BYTE_BITS  = 8;
  localparam int HALF_BITS  = 16;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } lsu_size_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
`ifdef LSU_MISALIGN_TRAP_EN
    RESP   = 3'd4,
    ERR    = 3'd5
`else
    RESP   = 3'd4
`endif
  } lsu_state_e;

  // Encoding 2'b11 behaves exactly like a word access.
  function automatic lsu_size_e norm_size(input logic [1:0] s);
    return (s == 2'b11) ? WORD : lsu_size_e'(s);
  endfunction

  function automatic logic is_misaligned(input lsu_size_e s, input logic [LANE_SEL_W-1:0] off);
    return ((s == HALF) && off[0]) || ((s == WORD) && (off != '0));
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Pipeline-side request/response bundle of the load/store unit.
// master = MEM stage, slave = load_store_unit.
interface lsu_if #(parameter int X_LEN = 32);
  logic             req_valid;
  logic             req_ready;
  logic             req_store;
  logic [1:0]       req_size;
  logic             req_unsigned;
  logic [X_LEN-1:0] req_addr;
  logic [X_LEN-1:0] req_wdata;
  logic             resp_valid;
  logic             resp_err;
  logic [X_LEN-1:0] resp_rdata;

  modport master (
    output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: extracts and extends load data from a memory word
// and merges right-aligned store data into a memory word.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int X_LEN = 32
) (
  input  lsu_size_e             size,
  input  logic [LANE_SEL_W-1:0] offset,
  input  logic                  is_unsigned,
  input  logic [X_LEN-1:0]      mem_word,
  input  logic [X_LEN-1:0]      store_data,
  output logic [X_LEN-1:0]      load_data,
  output logic [X_LEN-1:0]      store_word
);

  logic [4:0]       byte_pos;
  logic [4:0]       half_pos;
  logic [X_LEN-1:0] byte_sh;
  logic [X_LEN-1:0] half_sh;
  logic [X_LEN-1:0] byte_mask;
  logic [X_LEN-1:0] half_mask;
  logic [X_LEN-1:0] byte_ins;
  logic [X_LEN-1:0] half_ins;

  // Half accesses select the upper or lower pair of lanes from offset[1] alone.
  assign byte_pos  = {offset, 3'b000};
  assign half_pos  = {offset[LANE_SEL_W-1 -: HALF_SEL_W], 4'b0000};
  assign byte_sh   = mem_word >> byte_pos;
  assign half_sh   = mem_word >> half_pos;
  assign byte_mask = {{(X_LEN-BYTE_BITS){1'b0}}, {BYTE_BITS{1'b1}}} << byte_pos;
  assign half_mask = {{(X_LEN-HALF_BITS){1'b0}}, {HALF_BITS{1'b1}}} << half_pos;
  assign byte_ins  = {{(X_LEN-BYTE_BITS){1'b0}}, store_data[BYTE_BITS-1:0]} << byte_pos;
  assign half_ins  = {{(X_LEN-HALF_BITS){1'b0}}, store_data[HALF_BITS-1:0]} << half_pos;

  always_comb begin
    load_data  = mem_word;
    store_word = store_data;
    case (size)
      BYTE: begin
        load_data  = is_unsigned ? {{(X_LEN-BYTE_BITS){1'b0}}, byte_sh[BYTE_BITS-1:0]}
                                 : {{(X_LEN-BYTE_BITS){byte_sh[BYTE_BITS-1]}}, byte_sh[BYTE_BITS-1:0]};
        store_word = (mem_word & ~byte_mask) | byte_ins;
      end
      HALF: begin
        load_data  = is_unsigned ? {{(X_LEN-HALF_BITS){1'b0}}, half_sh[HALF_BITS-1:0]}
                                 : {{(X_LEN-HALF_BITS){half_sh[HALF_BITS-1]}}, half_sh[HALF_BITS-1:0]};
        store_word = (mem_word & ~half_mask) | half_ins;
      end
      default: begin
        load_data  = mem_word;
        store_word = store_data;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store per handshake, sub-word stores via read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to answer misaligned half/word accesses with an error response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int X_LEN = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  lsu_if.slave             bus,
  output logic             mem_we_o,
  output logic [X_LEN-1:0] mem_addr_o,
  output logic [X_LEN-1:0] mem_wdata_o,
  input  logic [X_LEN-1:0] mem_rdata_i
);

  lsu_state_e       state_q, state_d;
  logic             store_q;
  lsu_size_e        size_q;
  logic             unsigned_q;
  logic [X_LEN-1:0] addr_q;
  logic [X_LEN-1:0] wdata_q;
  logic [X_LEN-1:0] rdata_q;
  logic [X_LEN-1:0] align_load;
  logic [X_LEN-1:0] align_store;
  logic             accept;
  lsu_size_e        req_size_n;

  assign accept     = bus.req_valid && (state_q == IDLE);
  assign req_size_n = norm_size(bus.req_size);

  lsu_align #(.X_LEN(X_LEN)) u_align (
    .size        (size_q),
    .offset      (addr_q[LANE_SEL_W-1:0]),
    .is_unsigned (unsigned_q),
    .mem_word    (mem_rdata_i),
    .store_data  (wdata_q),
    .load_data   (align_load),
    .store_word  (align_store)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
`ifdef LSU_MISALIGN_TRAP_EN
          if (is_misaligned(req_size_n, bus.req_addr[LANE_SEL_W-1:0])) state_d = ERR;
          else
`endif
          if (!bus.req_store)           state_d = LOAD;
          else if (req_size_n == WORD)  state_d = WRITE;
          else                          state_d = RMW_RD;
        end
      end
      LOAD:   state_d = RESP;
      RMW_RD: state_d = WRITE;
      WRITE:  state_d = RESP;
      RESP:   state_d = IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
      ERR:    state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    mem_we_o       = (state_q == WRITE);
    mem_wdata_o    = (state_q == WRITE) ? wdata_q : '0;
`ifdef LSU_MISALIGN_TRAP_EN
    bus.resp_valid = (state_q == RESP) || (state_q == ERR);
    bus.resp_err   = (state_q == ERR);
`else
    bus.resp_valid = (state_q == RESP);
    bus.resp_err   = 1'b0;
`endif
  end

  assign mem_addr_o     = {addr_q[X_LEN-1:LANE_SEL_W], {LANE_SEL_W{1'b0}}};
  assign bus.resp_rdata = rdata_q;

  // rdata_q is cleared on accept so stores and errors respond with zero data;
  // wdata_q holds the raw store data until RMW_RD replaces it with the merged word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      store_q    <= 1'b0;
      size_q     <= BYTE;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      if (accept) begin
        store_q    <= bus.req_store;
        size_q     <= req_size_n;
        unsigned_q <= bus.req_unsigned;
        addr_q     <= bus.req_addr;
        wdata_q    <= bus.req_wdata;
        rdata_q    <= '0;
      end
      if (state_q == LOAD)   rdata_q <= align_load;
      if (state_q == RMW_RD) wdata_q <= align_store;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a word-addressed memory model with mem[i]=i.
// Expectations for misaligned accesses follow LSU_MISALIGN_TRAP_EN.
module tb_load_store_unit;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  lsu_if #(.X_LEN(32)) bus();

  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] mem [0:63];
  logic        mem_init = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  load_store_unit #(.X_LEN(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .bus         (bus),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk_i) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= i;
    end else if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  // Issues one request at a negedge and observes cycles 1..6 after the accept cycle.
  task automatic do_op(input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output int resp_cyc, output int resp_cnt, output logic err,
                       output logic [31:0] rdata, output int we_cnt, output int we_cyc,
                       output logic [31:0] we_data);
    resp_cyc = -1; resp_cnt = 0; err = 1'b0; rdata = '0;
    we_cnt = 0; we_cyc = -1; we_data = '0;
    @(negedge clk_i);
    bus.req_valid = 1'b1; bus.req_store = st; bus.req_size = sz;
    bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wd;
    @(posedge clk_i);
    #1 bus.req_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_i);
      if (mem_we) begin
        we_cnt++; we_cyc = c; we_data = mem_wdata;
      end
      if (bus.resp_valid) begin
        resp_cnt++;
        if (resp_cyc < 0) begin
          resp_cyc = c; err = bus.resp_err; rdata = bus.resp_rdata;
        end
      end
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    #1;
    n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
    n_tests++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
    n_tests++; if (bus.resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err: got %b want 0", bus.resp_err); end
    n_tests++; if (bus.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 00000000", bus.resp_rdata); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", mem_we); end
    n_tests++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 00000000", mem_addr); end
    n_tests++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 00000000", mem_wdata); end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0; mem_init = 1'b0;
  endtask

  task automatic test_word_load();
    int rc, rn, wn, wc; logic e; logic [31:0] rd, wdat;
    do_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rc, rn, e, rd, wn, wc, wdat);
    n_tests++; if (rc !== 2) begin n_fail++; $display("FAIL wload_cycle: got %0d want 2", rc); end
    n_tests++; if (rd !== 32'h4) begin n_fail++; $display("FAIL wload_data: got %h want 00000004", rd); end
    n_tests++; if (wn !== 0) begin n_fail++; $display("FAIL wload_we: got %0d want 0", wn); end
    n_tests++; if (rn !== 1 || e !== 1'b0) begin n_fail++; $display("FAIL wload_pulse: got cnt=%0d err=%b want cnt=1 err=0", rn, e); end
  endtask

  task automatic test_misalign();
    int rc, rn, wn, wc; logic e; logic [31:0] rd, wdat;
    do_op(1'b0, 2'b10, 1'b0, 32'h21, 32'h0, rc, rn, e, rd, wn, wc, wdat);
`ifdef LSU_MISALIGN_TRAP_EN
    n_tests++; if (rc !== 1) begin n_fail++; $display("FAIL mis_load_cycle: got %0d want 1", rc); end
    n_tests++; if (e !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL mis_load_err: got err=%b data=%h want err=1 data=00000000", e, rd); end
`else
    n_tests++; if (rc !== 2) begin n_fail++; $display("FAIL mis_load_cycle: got %0d want 2", rc); end
    n_tests++; if (e !== 1'b0 || rd !== 32'h8) begin n_fail++; $display("FAIL mis_load_data: got err=%b data=%h want err=0 data=00000008", e, rd); end
`endif
    n_tests++; if (wn !== 0) begin n_fail++; $display("FAIL mis_load_we: got %0d want 0", wn); end
    do_op(1'b1, 2'b01, 1'b0, 32'h31, 32'h00001234, rc, rn, e, rd, wn, wc, wdat);
    @(negedge clk_i);
`ifdef LSU_MISALIGN_TRAP_EN
    n_tests++; if (rc !== 1 || e !== 1'b1 || wn !== 0) begin n_fail++; $display("FAIL mis_store: got cyc=%0d err=%b we=%0d want cyc=1 err=1 we=0", rc, e, wn); end
    n_tests++; if (mem[12] !== 32'h0000000C) begin n_fail++; $display("FAIL mis_store_mem: got %h want 0000000c", mem[12]); end
`else
    n_tests++; if (rc !== 3 || e !== 1'b0 || wdat !== 32'h00001234) begin n_fail++; $display("FAIL mis_store: got cyc=%0d err=%b wdata=%h want cyc=3 err=0 wdata=00001234", rc, e, wdat); end
    n_tests++; if (mem[12] !== 32'h00001234) begin n_fail++; $display("FAIL mis_store_mem: got %h want 00001234", mem[12]); end
`endif
  endtask

  task automatic test_store_extend();
    int rc, rn, wn, wc; logic e; logic [31:0] rd, wdat;
    do_op(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, rc, rn, e, rd, wn, wc, wdat);
    n_tests++; if (rc !== 2 || rd !== 32'h0) begin n_fail++; $display("FAIL wstore_resp: got cyc=%0d data=%h want cyc=2 data=00000000", rc, rd); end
    n_tests++; if (wn !== 1 || wc !== 1 || wdat !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wstore_we: got cnt=%0d cyc=%0d data=%h want cnt=1 cyc=1 data=deadbeef", wn, wc, wdat); end
    n_tests++; if (mem[8] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wstore_mem: got %h want deadbeef", mem[8]); end
    do_op(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, rc, rn, e, rd, wn, wc, wdat);
    n_tests++; if (rd !== 32'hFFFFFFDE || rc !== 2) begin n_fail++; $display("FAIL lb_23: got %h cyc=%0d want ffffffde cyc=2", rd, rc); end
    do_op(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, rc, rn, e, rd, wn, wc, wdat);
    n_tests++; if (rd !== 32'h000000DE) begin n_fail++; $display("FAIL lbu_23: got %h want 000000de", rd); end
    do_op(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, rc, rn, e, rd, wn, wc, wdat);
    n_tests++; if (rd !== 32'hFFFFBEEF) begin n_fail++; $display("FAIL lh_20: got %h want ffffbeef", rd); end
    do_op(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, rc, rn, e, rd, wn, wc, wdat);
    n_tests++; if (rd !== 32'h0000DEAD) begin n_fail++; $display("FAIL lhu_22: got %h want 0000dead", rd); end
    do_op(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, rc, rn, e, rd, wn, wc, wdat);
    n_tests++; if (rd !== 32'hFFFFFFBE) begin n_fail++; $display("FAIL lb_21: got %h want ffffffbe", rd); end
    do_op(1'b0, 2'b11, 1'b1, 32'h20, 32'h0, rc, rn, e, rd, wn, wc, wdat);
    n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lsz11_20: got %h want deadbeef", rd); end
  endtask

  task automatic test_rmw();
    int rc, rn, wn, wc; logic e; logic [31:0] rd, wdat;
    do_op(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, rc, rn, e, rd, wn, wc, wdat);
    do_op(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000A55A, rc, rn, e, rd, wn, wc, wdat);
    n_tests++; if (wn !== 1 || wc !== 2) begin n_fail++; $display("FAIL sh_we: got cnt=%0d cyc=%0d want cnt=1 cyc=2", wn, wc); end
    n_tests++; if (wdat !== 32'hA55A3344) begin n_fail++; $display("FAIL sh_wdata: got %h want a55a3344", wdat); end
    n_tests++; if (rc !== 3 || rn !== 1 || rd !== 32'h0) begin n_fail++; $display("FAIL sh_resp: got cyc=%0d cnt=%0d data=%h want cyc=3 cnt=1 data=00000000", rc, rn, rd); end
    do_op(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFFCC, rc, rn, e, rd, wn, wc, wdat);
    @(negedge clk_i);
    n_tests++; if (wdat !== 32'hA55ACC44 || rc !== 3) begin n_fail++; $display("FAIL sb_wdata: got %h cyc=%0d want a55acc44 cyc=3", wdat, rc); end
    n_tests++; if (mem[8] !== 32'hA55ACC44) begin n_fail++; $display("FAIL sb_mem: got %h want a55acc44", mem[8]); end
  endtask

  task automatic test_reset_in_write();
    int rn = 0;
    @(negedge clk_i);
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h40; bus.req_wdata = 32'hCAFEF00D;
    @(posedge clk_i);
    #1 bus.req_valid = 1'b0;
    n_tests++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL rstw_in_write: got we=%b want 1", mem_we); end
    rst_i = 1'b1;
    #1;
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rstw_we_drop: got %b want 0", mem_we); end
    n_tests++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rstw_bus_clear: got addr=%h wdata=%h want 0 0", mem_addr, mem_wdata); end
    if (bus.resp_valid) rn++;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      if (bus.resp_valid) rn++;
    end
    n_tests++; if (rn !== 0) begin n_fail++; $display("FAIL rstw_no_resp: got %0d pulses want 0", rn); end
    n_tests++; if (mem[16] !== 32'h00000010) begin n_fail++; $display("FAIL rstw_mem: got %h want 00000010", mem[16]); end
    n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rstw_ready: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_back_to_back();
    int n_acc = 0, n_resp = 0;
    int acc_cyc [2] = '{-1, -1};
    int resp_cyc [2] = '{-1, -1};
    logic [31:0] resp_dat [2] = '{32'h0, 32'h0};
    logic rdy [8];
    @(negedge clk_i);
    bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h04; bus.req_wdata = '0;
    for (int c = 0; c < 8; c++) begin
      #1;
      rdy[c] = bus.req_ready;
      if (bus.req_valid && bus.req_ready && n_acc < 2) begin acc_cyc[n_acc] = c; n_acc++; end
      if (bus.resp_valid) begin
        if (n_resp < 2) begin resp_cyc[n_resp] = c; resp_dat[n_resp] = bus.resp_rdata; end
        n_resp++;
      end
      @(posedge clk_i);
      #1;
      if (n_acc == 1) bus.req_addr = 32'h08;
      if (n_acc == 2) bus.req_valid = 1'b0;
      @(negedge clk_i);
    end
    n_tests++; if (acc_cyc[0] !== 0 || acc_cyc[1] !== 3) begin n_fail++; $display("FAIL b2b_accept: got %0d,%0d want 0,3", acc_cyc[0], acc_cyc[1]); end
    n_tests++; if (rdy[1] !== 1'b0 || rdy[2] !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_busy: got %b,%b want 0,0", rdy[1], rdy[2]); end
    n_tests++; if (n_resp !== 2) begin n_fail++; $display("FAIL b2b_resp_count: got %0d want 2", n_resp); end
    n_tests++; if (resp_cyc[0] !== 2 || resp_dat[0] !== 32'h1) begin n_fail++; $display("FAIL b2b_first: got cyc=%0d data=%h want cyc=2 data=00000001", resp_cyc[0], resp_dat[0]); end
    n_tests++; if (resp_cyc[1] !== 5 || resp_dat[1] !== 32'h2) begin n_fail++; $display("FAIL b2b_second: got cyc=%0d data=%h want cyc=5 data=00000002", resp_cyc[1], resp_dat[1]); end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_misalign();
    test_store_extend();
    test_rmw();
    test_reset_in_write();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
